mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and the data-memory (MEM) stage of the 5-stage MIPS pipeline.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_timeout_cnt.sv | 32 +++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: encodings, default widths and the arbitration rule for the IF/MEM memory port arbiter
package mem_port_arbiter_pkg;

    localparam int ARB_WORD_LEN = 32;
    localparam int ARB_ADDR_LEN = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    // DATA wins unless IF is also waiting and DATA had the previous grant
    function automatic logic pick_dm(input logic dm_req, input logic if_req, input grant_t last_grant);
        return dm_req && (!if_req || last_grant == GRANT_IF);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// arb_timeout_cnt: counts cycles spent waiting for a memory acknowledge
// expired holds once the wait reaches TIMEOUT_CYC-1; TIMEOUT_CYC=0 disables it.
module arb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    if (TIMEOUT_CYC == 0) begin : g_off
        logic unused_in;
        assign unused_in = ^{clk, rst, clr, en};
        assign expired = 1'b0;
    end else begin : g_cnt
        localparam int W = $clog2(TIMEOUT_CYC + 1);
        localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
        logic [W-1:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                cnt <= '0;
            else if (clr)
                cnt <= '0;
            else if (en && !expired)
                cnt <= cnt + W'(1);
        end
        assign expired = cnt == LAST;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the data-memory stage
// Alternates grants under contention, freezes the pipeline while a request is unserved, aborts on timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN    = ARB_WORD_LEN,
    parameter int ADDR_LEN    = ARB_ADDR_LEN,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_ready,
    input  logic                dm_rd_en,
    input  logic                dm_wr_en,
    input  logic [ADDR_LEN-1:0] dm_addr,
    input  logic [WORD_LEN-1:0] dm_wdata,
    output logic [WORD_LEN-1:0] dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata,
    input  logic                mem_ack,
    output logic                freeze,
    output logic                err
);

    arb_state_t state;
    grant_t     grant;
    grant_t     last_grant;
    logic       dm_req;
    logic       expired;

    assign dm_req = dm_rd_en | dm_wr_en;
    // low in the ready cycle so the stalled stage advances exactly once
    assign freeze = (dm_req & ~dm_ready) | (if_req & ~if_ready);

    arb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ARB_ACC),
        .en      (state == ARB_ACC),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            grant      <= GRANT_IF;
            last_grant <= GRANT_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_dm(dm_req, if_req, last_grant)) begin
                        grant      <= GRANT_DM;
                        last_grant <= GRANT_DM;
                        mem_we     <= dm_wr_en;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        mem_req    <= 1'b1;
                        state      <= ARB_ACC;
                    end else if (if_req) begin
                        grant      <= GRANT_IF;
                        last_grant <= GRANT_IF;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_req    <= 1'b1;
                        state      <= ARB_ACC;
                    end
                end
                ARB_ACC: begin
                    // an ack in the expiry cycle still completes normally
                    if (mem_ack || expired) begin
                        mem_req <= 1'b0;
                        err     <= !mem_ack;
                        state   <= ARB_RESP;
                        if (grant == GRANT_DM) begin
                            dm_ready <= 1'b1;
                            if (!mem_ack || !mem_we)
                                dm_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end
                end
                ARB_RESP: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, dm_rd_en = 1'b0, dm_wr_en = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_req, mem_we, mem_ack, freeze, err;
    logic        model_ack = 1'b0, spur = 1'b0, prev_req = 1'b0;
    int          ack_lat = 0, wcnt = 0, nreq = 0, n_cmp = 0, n_bad = 0;

    mem_port_arbiter #(.WORD_LEN(32), .ADDR_LEN(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .freeze(freeze), .err(err)
    );

    always #5 clk = ~clk;

    // memory: data is a fixed function of the address, ack after ack_lat waiting cycles (-1 = never)
    assign mem_rdata = mem_addr ^ 32'hDEADBEFF;
    assign mem_ack   = model_ack | spur;

    always @(negedge clk) begin
        wcnt = mem_req ? wcnt + 1 : 0;
        model_ack = mem_req && ack_lat >= 0 && wcnt > ack_lat;
    end

    always @(posedge clk) begin
        if (mem_req && !prev_req) nreq++;
        prev_req = mem_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        int n0;
        step(2);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_if_rdy", if_ready, 0);
        check("rst_dm_rdy", dm_ready, 0);
        check("rst_err", err, 0);
        check("rst_frz", freeze, 0);
        check("rst_if_data", if_rdata, 0);
        check("rst_dm_data", dm_rdata, 0);
        rst = 1'b1;

        // 1: IF-only read, ack in first ACC cycle
        if_req = 1'b1; if_addr = 32'h10; ack_lat = 0;
        #1;
        check("t1_frz_c0", freeze, 1);
        check("t1_req_c0", mem_req, 0);
        step(1);
        check("t1_req_c1", mem_req, 1);
        check("t1_addr", mem_addr, 32'h10);
        check("t1_we", mem_we, 0);
        check("t1_frz_c1", freeze, 1);
        step(1);
        check("t1_rdy", if_ready, 1);
        check("t1_data", if_rdata, 32'hDEADBEEF);
        check("t1_frz_c2", freeze, 0);
        check("t1_req_c2", mem_req, 0);
        if_req = 1'b0;
        step(1);
        check("t1_pulse", if_ready, 0);
        check("t1_frz_c3", freeze, 0);

        // 2: contention from reset, grants DATA, IF, DATA
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        dm_rd_en = 1'b1; dm_addr = 32'h200;
        step(1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("t2_req", mem_req, 1);
            check("t2_grant", mem_addr, k == 1 ? 32'h100 : 32'h200);
            step(1);
            check("t2_dm_rdy", dm_ready, k != 1);
            check("t2_if_rdy", if_ready, k == 1);
            step(1);
            check("t2_idle", mem_req, 0);
        end
        if_req = 1'b0; dm_rd_en = 1'b0;
        check("t2_dm_data", dm_rdata, 32'hDEADBCFF);
        check("t2_if_data", if_rdata, 32'hDEADBFFF);

        // 3: write takes precedence over read when both enables are set
        dm_rd_en = 1'b1; dm_wr_en = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h12345678;
        step(1);
        check("t3_req", mem_req, 1);
        check("t3_we", mem_we, 1);
        check("t3_addr", mem_addr, 32'h40);
        check("t3_wdata", mem_wdata, 32'h12345678);
        step(1);
        check("t3_rdy", dm_ready, 1);
        check("t3_data_kept", dm_rdata, 32'hDEADBCFF);
        dm_rd_en = 1'b0; dm_wr_en = 1'b0;
        step(1);
        check("t3_pulse", dm_ready, 0);
        step(1);
        check("t3_no_reissue", mem_req, 0);

        // 4: memory never acks
        ack_lat = -1; dm_rd_en = 1'b1; dm_addr = 32'h80; n = 0;
        for (int c = 0; c < 40 && !dm_ready; c++) begin
            step(1);
            if (mem_req) n++;
        end
        check("t4_req_cycles", n, 16);
        check("t4_rdy", dm_ready, 1);
        check("t4_err", err, 1);
        check("t4_data", dm_rdata, 0);
        dm_rd_en = 1'b0;
        step(1);
        check("t4_err_pulse", err, 0);
        check("t4_rdy_pulse", dm_ready, 0);
        step(1);
        check("t4_idle", mem_req, 0);

        // 5: reset asserted while in ACC
        if_req = 1'b1; if_addr = 32'h300;
        step(2);
        check("t5_acc", mem_req, 1);
        rst = 1'b0;
        #1;
        check("t5_req_drop", mem_req, 0);
        check("t5_if_rdy", if_ready, 0);
        check("t5_err", err, 0);
        check("t5_frz", freeze, 1);
        step(1);
        ack_lat = 0; rst = 1'b1;
        step(1);
        check("t5_reissue", mem_req, 1);
        check("t5_addr", mem_addr, 32'h300);
        step(1);
        check("t5_rdy", if_ready, 1);
        check("t5_data", if_rdata, 32'hDEADBDFF);
        if_req = 1'b0;

        // 6: late ack, request held through RESP, spurious ack in IDLE
        step(1);
        ack_lat = 3; dm_rd_en = 1'b1; dm_addr = 32'h44; n0 = nreq;
        step(1);
        check("t6_req_c1", mem_req, 1);
        step(3);
        check("t6_req_c4", mem_req, 1);
        check("t6_rdy_early", dm_ready, 0);
        step(1);
        check("t6_rdy", dm_ready, 1);
        check("t6_req_resp", mem_req, 0);
        check("t6_data", dm_rdata, 32'hDEADBEBB);
        check("t6_frz", freeze, 0);
        step(1);
        check("t6_rdy_pulse", dm_ready, 0);
        check("t6_req_c6", mem_req, 0);
        dm_rd_en = 1'b0;
        step(1);
        spur = 1'b1;
        step(1);
        spur = 1'b0;
        check("t6_spur_rdy", dm_ready, 0);
        check("t6_spur_if_rdy", if_ready, 0);
        check("t6_spur_err", err, 0);
        check("t6_spur_req", mem_req, 0);
        step(1);
        check("t6_data_kept", dm_rdata, 32'hDEADBEBB);
        check("t6_one_req", nreq - n0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
